slice_sched: RTL and testbench

Round-robin scheduler that shares one 8-bit bit-slice engine (pass, bit-reverse, nibble swap, field extract) between `N_REQ` requesters. It accepts at most one request per cycle over a valid/ready handshake and drives the sliced result through a one-deep output register tagged with the requester ID. It sits between the stimulus/control masters and the slice datapath, and replaces ad-hoc direct drive of the slice unit.

---
 rtl/slice_pkg.sv | 48 ++++
 rtl/slice_unit.sv | 21 ++
 rtl/slice_sched.sv | 125 ++++++++++++
 tb/tb_slice_sched.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/slice_pkg.sv
// ---------------------------------------------------------------------------
// slice_pkg
// Shared definitions for the slice scheduler: operation encoding, engine width
// and the pure bit-slice function used by both the datapath and the bench.
// ---------------------------------------------------------------------------
package slice_pkg;

   localparam int SLICE_W = 8;

   typedef enum logic [1:0] {
      OP_PASS = 2'b00,
      OP_REV  = 2'b01,
      OP_SWAP = 2'b10,
      OP_EXT  = 2'b11
   } slice_op_t;

   // fld = {hi[2:0], lo[2:0]}; only OP_EXT looks at it.
   function automatic logic [SLICE_W-1:0] slice_fn(input logic [SLICE_W-1:0] d,
                                                   input slice_op_t          op,
                                                   input logic [5:0]         fld);
      logic [SLICE_W-1:0] r;
      logic [SLICE_W-1:0] sh;
      logic [2:0]         hi;
      logic [2:0]         lo;
      r  = '0;
      sh = '0;
      hi = fld[5:3];
      lo = fld[2:0];
      case (op)
         OP_PASS: r = d;
         OP_REV: begin
            for (int j = 0; j < SLICE_W; j++) r[j] = d[SLICE_W-1-j];
         end
         OP_SWAP: r = {d[3:0], d[7:4]};
         default: begin
            // Inverted field (lo > hi) yields zero.
            if (lo <= hi) begin
               sh = d >> lo;
               for (int j = 0; j < SLICE_W; j++) begin
                  if (j <= int'(hi - lo)) r[j] = sh[j];
               end
            end
         end
      endcase
      return r;
   endfunction

endpackage

// File: rtl/slice_unit.sv
// ---------------------------------------------------------------------------
// slice_unit
// Combinational 8-bit bit-slice engine.
// Ports:
//   data_i   in  8  operand
//   op_i     in  2  operation (slice_op_t encoding)
//   fld_i    in  6  field select {hi, lo} for extract
//   result_o out 8  sliced result
// ---------------------------------------------------------------------------
module slice_unit
   import slice_pkg::*;
(
   input  logic [SLICE_W-1:0] data_i,
   input  logic [1:0]         op_i,
   input  logic [5:0]         fld_i,
   output logic [SLICE_W-1:0] result_o
);

   assign result_o = slice_fn(data_i, slice_op_t'(op_i), fld_i);

endmodule

// File: rtl/slice_sched.sv
// ---------------------------------------------------------------------------
// slice_sched
// Round-robin scheduler sharing one slice_unit between N_REQ requesters.
// One request accepted per cycle; result held in a one-deep output register
// tagged with the requester index.
// Ports:
//   clk_i        in   1        clock, rising edge
//   rst_n_i      in   1        asynchronous active-low reset
//   req_valid_i  in   N_REQ    per-requester request valid
//   req_ready_o  out  N_REQ    one-hot grant (combinational)
//   req_data_i   in   N_REQ*W  operands, requester k at [k*W +: W]
//   req_op_i     in   N_REQ*2  operations, requester k at [k*2 +: 2]
//   req_fld_i    in   N_REQ*6  field selects, requester k at [k*6 +: 6]
//   out_valid_o  out  1        result valid
//   out_ready_i  in   1        downstream accepts result
//   out_data_o   out  W        result
//   out_id_o     out  3        producing requester index
//   txn_cnt_o    out  16       saturating completed-output count
// ---------------------------------------------------------------------------
module slice_sched
   import slice_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int W     = 8
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic [N_REQ-1:0]   req_valid_i,
   output logic [N_REQ-1:0]   req_ready_o,
   input  logic [N_REQ*W-1:0] req_data_i,
   input  logic [N_REQ*2-1:0] req_op_i,
   input  logic [N_REQ*6-1:0] req_fld_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [W-1:0]       out_data_o,
   output logic [2:0]         out_id_o,
   output logic [15:0]        txn_cnt_o
);

   logic          r_out_valid;
   logic [W-1:0]  r_out_data;
   logic [2:0]    r_out_id;
   logic [15:0]   r_txn_cnt;
   logic [2:0]    r_ptr;

   logic          w_free;
   logic          w_gnt_any;
   logic [2:0]    w_gnt_idx;
   logic          w_grant;
   logic [2:0]    w_ptr_nxt;
   logic [W-1:0]  w_sel_data;
   logic [1:0]    w_sel_op;
   logic [5:0]    w_sel_fld;
   logic [W-1:0]  w_result;
   int            w_scan;

   assign w_free = !r_out_valid || out_ready_i;

   // First valid requester at or after r_ptr, wrapping modulo N_REQ.
   always_comb begin
      w_gnt_any = 1'b0;
      w_gnt_idx = '0;
      w_scan    = 0;
      for (int i = 0; i < N_REQ; i++) begin
         w_scan = int'(r_ptr) + i;
         if (w_scan >= N_REQ) w_scan = w_scan - N_REQ;
         if (!w_gnt_any && req_valid_i[w_scan]) begin
            w_gnt_any = 1'b1;
            w_gnt_idx = 3'(w_scan);
         end
      end
   end

   assign w_grant   = w_free && w_gnt_any;
   assign w_ptr_nxt = (w_gnt_idx == 3'(N_REQ - 1)) ? 3'd0 : w_gnt_idx + 3'd1;

   always_comb begin
      req_ready_o = '0;
      for (int k = 0; k < N_REQ; k++) begin
         req_ready_o[k] = w_grant && (w_gnt_idx == 3'(k));
      end
   end

   assign w_sel_data = req_data_i[int'(w_gnt_idx)*W +: W];
   assign w_sel_op   = req_op_i[int'(w_gnt_idx)*2 +: 2];
   assign w_sel_fld  = req_fld_i[int'(w_gnt_idx)*6 +: 6];

   slice_unit u_slice (
      .data_i   (w_sel_data),
      .op_i     (w_sel_op),
      .fld_i    (w_sel_fld),
      .result_o (w_result)
   );

   // Output register: a grant reloads it even while draining (no bubble).
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_id    <= '0;
         r_ptr       <= '0;
      end else if (w_grant) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_result;
         r_out_id    <= w_gnt_idx;
         r_ptr       <= w_ptr_nxt;
      end else if (out_ready_i) begin
         r_out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_txn_cnt <= '0;
      end else if (r_out_valid && out_ready_i && (r_txn_cnt != 16'hFFFF)) begin
         r_txn_cnt <= r_txn_cnt + 16'd1;
      end
   end

   assign out_valid_o = r_out_valid;
   assign out_data_o  = r_out_data;
   assign out_id_o    = r_out_id;
   assign txn_cnt_o   = r_txn_cnt;

endmodule

// File: tb/tb_slice_sched.sv
module tb_slice_sched;
   import slice_pkg::*;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  req_valid;
   logic [N-1:0]  req_ready;
   logic [N*8-1:0] req_data;
   logic [N*2-1:0] req_op;
   logic [N*6-1:0] req_fld;
   logic          out_valid;
   logic          out_ready;
   logic [7:0]    out_data;
   logic [2:0]    out_id;
   logic [15:0]   txn_cnt;

   logic [7:0]    d   [N];
   logic [1:0]    op  [N];
   logic [5:0]    fld [N];

   typedef struct packed {
      logic [2:0] id;
      logic [7:0] data;
   } exp_t;
   exp_t q[$];

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   always_comb begin
      for (int k = 0; k < N; k++) begin
         req_data[k*8 +: 8] = d[k];
         req_op[k*2 +: 2]   = op[k];
         req_fld[k*6 +: 6]  = fld[k];
      end
   end

   slice_sched #(.N_REQ(N), .W(8)) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_data_i  (req_data),
      .req_op_i    (req_op),
      .req_fld_i   (req_fld),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (out_data),
      .out_id_o    (out_id),
      .txn_cnt_o   (txn_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Monitor: every transfer on the output side is matched to the queue head.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_output", {21'd0, out_id, out_data}, 32'hFFFF_FFFF);
            end else begin
               e = q.pop_front();
               chk("out_id_data", {21'd0, out_id, out_data}, {21'd0, e.id, e.data});
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int k, input logic [7:0] dd, input logic [1:0] oo,
                          input logic [5:0] ff);
      d[k] = dd; op[k] = oo; fld[k] = ff;
   endtask

   task automatic load_std();
      set_req(0, 8'h12, 2'b00, 6'd0);
      set_req(1, 8'h01, 2'b01, 6'd0);
      set_req(2, 8'h3C, 2'b10, 6'd0);
      set_req(3, 8'hD6, 2'b11, 6'b101_010);
   endtask

   // Hand-computed results of load_std per requester.
   function automatic exp_t std_exp(input int k);
      exp_t e;
      e.id = 3'(k);
      case (k)
         0: e.data = 8'h12;
         1: e.data = 8'h80;
         2: e.data = 8'hC3;
         default: e.data = 8'h05;
      endcase
      return e;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int order[8];
      exp_t e;
      logic [7:0] held_data;
      rst_n = 1'b0; req_valid = '0; out_ready = 1'b0;
      for (int k = 0; k < N; k++) set_req(k, 8'h00, 2'b00, 6'd0);
      #12;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data",  32'(out_data),  32'd0);
      chk("rst_id",    32'(out_id),    32'd0);
      chk("rst_cnt",   32'(txn_cnt),   32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      step();

      // Single request: reverse of 0xB1.
      set_req(0, 8'hB1, 2'b01, 6'd0);
      req_valid = 4'b0001; out_ready = 1'b1;
      #1 chk("single_ready", 32'(req_ready), 32'h1);
      e.id = 3'd0; e.data = 8'h8D; q.push_back(e);
      step();
      req_valid = '0;
      chk("single_valid_lat1", 32'(out_valid), 32'd1);
      step();
      chk("single_cnt", 32'(txn_cnt), 32'd1);

      // All four valid, ptr now 1: order 1,2,3,0,1,2,3,0.
      load_std();
      order = '{1, 2, 3, 0, 1, 2, 3, 0};
      req_valid = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         #1 chk("rr_ready", 32'(req_ready), 32'(1 << order[i]));
         q.push_back(std_exp(order[i]));
         step();
      end
      req_valid = '0;
      step();

      // Extract with inverted field on requester 2 (ptr 1 -> grant 2).
      set_req(2, 8'hFF, 2'b11, 6'b001_100);
      req_valid = 4'b0100;
      e.id = 3'd2; e.data = 8'h00; q.push_back(e);
      step();
      req_valid = '0;
      step();

      // Back-pressure: ptr 3 -> grant 3, then hold 5 cycles.
      load_std();
      req_valid = 4'b1111;
      q.push_back(std_exp(3));
      step();
      out_ready = 1'b0;
      held_data = 8'h05;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_ready_zero", 32'(req_ready), 32'd0);
         chk("bp_hold", {21'd0, out_valid, out_id, out_data}, {21'd0, 1'b1, 3'd3, held_data});
         step();
      end
      out_ready = 1'b1;
      #1 chk("bp_release_ready", 32'(req_ready), 32'h1);
      q.push_back(std_exp(0));
      step();
      req_valid = '0;
      chk("bp_no_bubble", {28'd0, out_valid, out_id}, {28'd0, 1'b1, 3'd0});
      step();
      step();
      chk("cnt_before_sat", 32'(txn_cnt), 32'd12);

      // Saturation: preload 0xFFFD, three completions.
      @(negedge clk);
      force dut.r_txn_cnt = 16'hFFFD;
      #1 release dut.r_txn_cnt;
      step();
      set_req(0, 8'h55, 2'b00, 6'd0);
      req_valid = 4'b0001;
      for (int i = 0; i < 3; i++) begin
         e.id = 3'd0; e.data = 8'h55; q.push_back(e);
         step();
      end
      req_valid = '0;
      step();
      step();
      chk("cnt_saturate", 32'(txn_cnt), 32'hFFFF);

      // Async reset with a result pending (ptr 1 -> grant 1, ptr becomes 2).
      load_std();
      req_valid = 4'b0010;
      e = std_exp(1); q.push_back(e);
      step();
      out_ready = 1'b0;
      req_valid = '0;
      #1 rst_n = 1'b0;
      #1;
      void'(q.pop_back());
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_data",  32'(out_data),  32'd0);
      chk("arst_id",    32'(out_id),    32'd0);
      chk("arst_cnt",   32'(txn_cnt),   32'd0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      step();
      out_ready = 1'b1;
      req_valid = 4'b1010;
      #1 chk("arst_first_grant", 32'(req_ready), 32'h2);
      q.push_back(std_exp(1));
      step();
      req_valid = '0;
      step();
      step();
      chk("post_rst_cnt", 32'(txn_cnt), 32'd1);
      chk("queue_drained", 32'(q.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
